// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks registers 0..NUM_REGS-1 through a spare asynchronous read port of
//   the register file and streams each value out on a valid/ready interface.
//   The reader never writes the register file.
//
//   Optional build macro REGDUMP_CHECKSUM_EN: appends one extra beat after
//   the last register. That beat has out_index all ones and carries the XOR
//   of every value sent in the dump. In this build only that beat has
//   out_last set.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle dump request, sampled only while idle
//   busy       registered, high while a dump is in progress
//   rf_addr    register file read address
//   rf_rdata   combinational read data for rf_addr
//   out_valid  beat available
//   out_ready  consumer accepts the beat
//   out_index  register index of the current beat
//   out_data   register value of the current beat
//   out_last   final beat of the dump
//   done       one-cycle pulse after the final beat handshake
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_FINISH, S_CSUM} state_t;
    logic [DATA_W-1:0] acc;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_FINISH} state_t;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              hs;

    assign hs      = out_valid && out_ready;
    assign rf_addr = (state == S_FETCH) ? idx : '0;
    assign done    = (state == S_FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_SEND;
            S_SEND: begin
                if (hs) begin
                    if (out_last) begin
                        state_nxt = S_FINISH;
`ifdef REGDUMP_CHECKSUM_EN
                    end else if (idx == LAST_IDX) begin
                        state_nxt = S_CSUM;
`endif
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM:   state_nxt = S_SEND;
`endif
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            busy <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                        acc <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    out_data  <= rf_rdata;
                    out_index <= idx;
                    out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (idx == LAST_IDX);
`endif
                end
                S_SEND: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        // Guarding on LAST_IDX keeps idx in range even when
                        // the checksum beat follows the last register.
                        if (!out_last && idx != LAST_IDX) idx <= idx + 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        if (!out_last) acc <= acc ^ out_data;
`endif
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    out_data  <= acc;
                    out_index <= '1;
                    out_last  <= 1'b1;
                    out_valid <= 1'b1;
                end
`endif
                S_FINISH: begin
                    out_last <= 1'b0;
                    idx      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    localparam int NUM = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int BEATS = NUM + 1;
`else
    localparam int BEATS = NUM;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;

    logic [31:0] rf [NUM];

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int beats = 0;
    int dones = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_addr];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .out_last(out_last),
        .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake happens at the coming rising edge; inputs only change just
    // after a rising edge, so the falling edge sees the accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                beats++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(out_index), 64'hFFFF);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    check("beat_index", 64'(out_index), 64'(b.idx));
                    check("beat_data", 64'(out_data), 64'(b.data));
                    check("beat_last", 64'(out_last), 64'(b.last));
                end
            end
            if (done) dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [31:0] x;
        beat_t b;
        x = '0;
        for (int i = 0; i < NUM; i++) begin
            b.idx  = 5'(i);
            b.data = rf[i];
`ifdef REGDUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NUM - 1);
`endif
            x = x ^ rf[i];
            sb.push_back(b);
        end
`ifdef REGDUMP_CHECKSUM_EN
        b.idx  = 5'h1F;
        b.data = x;
        b.last = 1'b1;
        sb.push_back(b);
`endif
    endtask

    task automatic start_dump();
        push_dump();
        beats = 0;
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("valid_in_fetch", 64'(out_valid), 64'd0);
        tick();
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_index", 64'(out_index), 64'd0);
    endtask

    task automatic finish_dump();
        int n;
        n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        tick();
        check("busy_idle", 64'(busy), 64'd0);
        check("done_cleared", 64'(done), 64'd0);
        check("beat_count", 64'(beats), 64'(BEATS));
        check("done_count", 64'(dones), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_fetch(input logic [4:0] k);
        int n;
        n = 0;
        while (!(busy && !out_valid && rf_addr == k) && n < 500) begin
            tick();
            n++;
        end
        check("fetch_reached", 64'(rf_addr), 64'(k));
    endtask

    task automatic wait_send(input logic [4:0] k);
        int n;
        n = 0;
        while (!(out_valid && out_index == k) && n < 500) begin
            tick();
            n++;
        end
        check("send_reached", 64'(out_index), 64'(k));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_addr"}, 64'(rf_addr), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_index"}, 64'(out_index), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM; i++) rf[i] = '0;
        rf[1] = 32'd190;
        rf[2] = 32'd450;
        #3;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Plain dump with the consumer always ready.
        start_dump();
        finish_dump();

        // Backpressure on index 2, plus a start pulse while busy.
        start_dump();
        wait_fetch(5'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_index", 64'(out_index), 64'd2);
            check("bp_data", 64'(out_data), 64'd450);
        end
        out_ready = 1'b1;
        tick();
        check("bp_released", 64'(out_valid), 64'd0);
        tick();
        check("bp_next_index", 64'(out_index), 64'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_dump();

        // Asynchronous reset while index 5 is on the output.
        start_dump();
        wait_send(5'd5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start_dump();
        finish_dump();

        // Write to x3 after its fetch: old value in this dump, new in the next.
        start_dump();
        wait_fetch(5'd3);
        tick();
        rf[3] = 32'd7;
        finish_dump();
        start_dump();
        finish_dump();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader for the CPU register file's asynchronous read port; walks every architectural register and streams each value out on a valid/ready interface.
- Sits beside the register file on a spare read port. Used by debug/trace logic and by benches to dump architectural state after a program completes.
- Never writes the register file.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1); must be ≥2 and ≤2^ADDR_W.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- rf_addr  out  ADDR_W  address to the register file read port.
- rf_rdata  in  DATA_W  combinational read data returned for rf_addr.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_index  out  ADDR_W  register index of the current beat.
- out_data  out  DATA_W  register value of the current beat.
- out_last  out  1  marks the final beat of a dump.
- done  out  1  one-cycle pulse after the final beat handshake.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, rf_addr=0, out_valid=0, out_index=0, out_data=0, out_last=0, busy=0, done=0. All state is cleared immediately, including mid-dump; a partially sent beat is dropped.
- States: IDLE, FETCH, SEND, FINISH.
- IDLE:
  - rf_addr=0.
  - If start=1, then idx<=0 and go to FETCH.
- FETCH:
  - rf_addr=idx.
  - At the clock edge: out_data<=rf_rdata, out_index<=idx, out_last<=(idx==NUM_REGS-1), out_valid<=1. Go to SEND.
- SEND:
  - out_valid=1. out_index, out_data and out_last are held stable until the handshake.
  - Handshake = out_valid && out_ready at the rising edge.
  - On handshake with out_last=0: out_valid<=0, idx<=idx+1, go to FETCH.
  - On handshake with out_last=1: out_valid<=0, go to FINISH.
  - With no handshake, remain in SEND indefinitely; backpressure has unbounded length.
- FINISH:
  - done=1 for exactly one cycle.
  - out_last<=0, idx<=0, go to IDLE.
- busy is a registered output, high in FETCH, SEND and FINISH.
- Timing:
  - start accepted at edge E0 → first out_valid high after edge E1, i.e. 2 edges of latency.
  - With out_ready held high, each beat takes 2 cycles (FETCH+SEND). A full 32-register dump takes 64 cycles plus 1 cycle of FINISH.
- start asserted while busy=1 is ignored and not queued.
- Index 0 is read like every other index; its value is whatever the register file returns (0 for x0).
- Values are not a snapshot. Each register is sampled in its own FETCH cycle, so a write to register k before k's FETCH cycle is visible in the dump, and a write after it is not. Same-cycle write and read follows the register file's read-during-write behaviour.
- idx never exceeds NUM_REGS-1. No wrap-around occurs within a dump.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - An extra state CSUM follows the handshake of register NUM_REGS-1, which then has out_last=0.
  - CSUM presents a single beat with out_index=all ones, out_data=XOR of all DATA_W values sent in this dump, and out_last=1.
  - The running XOR accumulator resets to 0 on rst_n and on start acceptance.
  - After the CSUM handshake, go to FINISH.
  - Dump length becomes NUM_REGS+1 beats.
- Not defined: no CSUM state, no accumulator logic, and behaviour exactly as described above.

Test Plan:
- Preload x1=190, x2=450, other registers 0; pulse start, out_ready=1 → 32 beats with indices 0..31, data 0,190,450,0…; out_last only on index 31; done pulses once; busy low afterwards.
- Hold out_ready=0 for 10 cycles on the beat for index 2 → out_valid stays high, out_index=2 and out_data=450 stay stable; beat accepted on the release cycle and the dump continues with index 3.
- Pulse start again while busy=1 during the dump → ignored; exactly 32 beats and one done pulse.
- Assert rst_n=0 while in SEND for index 5 → all outputs return to reset values immediately; a new start yields a complete dump beginning at index 0.
- Write x3=7 in the cycle after index 3's FETCH → the beat for index 3 reports the old value 0, and a second dump reports 7.
- With REGDUMP_CHECKSUM_EN defined, x1=190, x2=450 → 33 beats; final beat has out_index=31 (all ones) and out_data=190^450=0x17C with out_last=1; the beat for index 31 has out_last=0.
